// File: rtl/can_frame_rx_destuff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : can_frame_rx_destuff                                             |
// | Brief   : CAN 2.0A bit receiver with mid-bit sampling and bit destuffing;  |
// |           assembles a fixed 108-bit standard data frame. Optional CRC-15   |
// |           check enabled by defining CAN_RX_CRC_CHECK_EN.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module can_frame_rx_destuff #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    input  logic         i_Rx_Serial,
    output logic         o_Rx_DV,
    output logic [0:107] o_Rx_Byte,
    output logic         o_Stuff_Err,
`ifdef CAN_RX_CRC_CHECK_EN
    output logic         o_Crc_Err,
`endif
    output logic         o_Busy
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1   = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [6:0]         c_LAST_BIT  = 7'd107;
    localparam logic [6:0]         c_LAST_STUF = 7'd97;
    localparam logic [6:0]         c_LAST_CRC  = 7'd82;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_START     = 2'd1;
    localparam logic [1:0] c_ST_DATA      = 2'd2;
    localparam logic [1:0] c_ST_WAIT_IDLE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         r_rx_sync;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [6:0]         r_bit_idx;
    logic [2:0]         r_run;
    logic               r_run_val;
    logic [0:106]       r_shift;

    logic w_rx;
    logic w_is_stuff;

`ifdef CAN_RX_CRC_CHECK_EN
    logic [14:0] r_crc;

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic din);
        logic [14:0] v;
        v = {crc[13:0], 1'b0};
        if (din ^ crc[14])
            v = v ^ 15'h4599;
        return v;
    endfunction
`endif

    assign w_rx = r_rx_sync[1];
    // The bit after a run of five may be a stuff bit, including the one right after the last CRC bit.
    assign w_is_stuff = (r_run == 3'd5) && (r_bit_idx <= (c_LAST_STUF + 7'd1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            r_rx_sync <= 2'b11;
        else
            r_rx_sync <= {r_rx_sync[0], i_Rx_Serial};
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= c_ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_run       <= '0;
            r_run_val   <= 1'b0;
            r_shift     <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= '0;
            o_Stuff_Err <= 1'b0;
            o_Busy      <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
            r_crc       <= '0;
            o_Crc_Err   <= 1'b0;
`endif
        end else begin
            o_Rx_DV     <= 1'b0;
            o_Stuff_Err <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
            o_Crc_Err   <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_run     <= '0;
                    if (!w_rx) begin
                        r_state <= c_ST_START;
                        o_Busy  <= 1'b1;
                    end
                end

                c_ST_START: begin
                    if (r_clk_cnt == c_HALF_M1) begin
                        r_clk_cnt <= '0;
                        if (!w_rx) begin
                            r_shift[0] <= 1'b0;
                            r_bit_idx  <= 7'd1;
                            r_run      <= 3'd1;
                            r_run_val  <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
                            r_crc      <= crc_step(15'd0, 1'b0);
`endif
                            r_state    <= c_ST_DATA;
                        end else begin
                            r_state <= c_ST_IDLE;
                            o_Busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                c_ST_DATA: begin
                    if (r_clk_cnt == c_FULL_M1) begin
                        r_clk_cnt <= '0;
                        if (w_is_stuff) begin
                            if (w_rx != r_run_val) begin
                                r_run     <= 3'd1;
                                r_run_val <= w_rx;
                            end else begin
                                o_Stuff_Err <= 1'b1;
                                o_Busy      <= 1'b0;
                                r_state     <= c_ST_WAIT_IDLE;
                            end
                        end else if (r_bit_idx == c_LAST_BIT) begin
                            o_Rx_Byte <= {r_shift, w_rx};
                            o_Rx_DV   <= 1'b1;
                            o_Busy    <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
                            o_Crc_Err <= (r_crc != r_shift[83:97]);
`endif
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_shift[r_bit_idx] <= w_rx;
                            r_bit_idx          <= r_bit_idx + 7'd1;
                            if (r_bit_idx <= c_LAST_STUF) begin
                                if (w_rx == r_run_val) begin
                                    r_run <= r_run + 3'd1;
                                end else begin
                                    r_run     <= 3'd1;
                                    r_run_val <= w_rx;
                                end
                            end
`ifdef CAN_RX_CRC_CHECK_EN
                            if (r_bit_idx <= c_LAST_CRC)
                                r_crc <= crc_step(r_crc, w_rx);
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                c_ST_WAIT_IDLE: begin
                    if (w_rx)
                        r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_can_frame_rx_destuff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_can_frame_rx_destuff                                          |
// | Brief   : Scoreboard bench for can_frame_rx_destuff (bit-stuffed frames,   |
// |           stuff errors, glitches, mid-frame reset, optional CRC check).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_can_frame_rx_destuff;

    localparam int CLKS = 10;

    logic         i_Clock;
    logic         i_Reset;
    logic         i_Rx_Serial;
    logic         o_Rx_DV;
    logic [0:107] o_Rx_Byte;
    logic         o_Stuff_Err;
    logic         o_Busy;
`ifdef CAN_RX_CRC_CHECK_EN
    logic         o_Crc_Err;
`endif

    can_frame_rx_destuff #(.CLKS_PER_BIT(CLKS)) u_dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Stuff_Err (o_Stuff_Err),
`ifdef CAN_RX_CRC_CHECK_EN
        .o_Crc_Err   (o_Crc_Err),
`endif
        .o_Busy      (o_Busy)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    typedef struct {
        bit           is_err;
        logic [0:107] frame;
        bit           crc_err;
    } exp_t;

    exp_t         sb[$];
    logic [0:107] last_good;
    int           n_checks;
    int           n_errors;

    task automatic check_value(input string tag, input logic [107:0] got, input logic [107:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] crc15(input logic [0:107] f);
        logic [14:0] c;
        logic        nxt;
        c = '0;
        for (int i = 0; i <= 82; i++) begin
            nxt = f[i] ^ c[14];
            c   = {c[13:0], 1'b0};
            if (nxt)
                c = c ^ 15'h4599;
        end
        return c;
    endfunction

    function automatic logic [0:107] make_frame(input logic [10:0] id, input logic [3:0] dlc,
                                                 input logic [63:0] data, input logic [14:0] crc);
        return {1'b0, id, 3'b000, dlc, data, crc, 1'b1, 1'b0, 1'b1, 7'h7F};
    endfunction

    // Inserts the complement after every run of five equal bits from SOF through the last CRC bit.
    function automatic void stuff_frame(input logic [0:107] f, output logic [0:127] s, output int n);
        int   run;
        logic val;
        s   = '1;
        n   = 0;
        run = 0;
        val = 1'b1;
        for (int i = 0; i < 108; i++) begin
            s[n] = f[i];
            n++;
            if (i <= 97) begin
                if (i > 0 && f[i] == val) begin
                    run++;
                end else begin
                    run = 1;
                    val = f[i];
                end
                if (run == 5) begin
                    s[n] = ~val;
                    n++;
                    run = 1;
                    val = ~val;
                end
            end
        end
    endfunction

    task automatic idle_bits(input int nbits);
        i_Rx_Serial = 1'b1;
        repeat (nbits * CLKS) @(negedge i_Clock);
    endtask

    task automatic drive_bits(input logic [0:127] b, input int n, input int abort_at);
        for (int i = 0; i < n; i++) begin
            i_Rx_Serial = b[i];
            if (i == abort_at) begin
                repeat (3) @(negedge i_Clock);
                check_value("busy_before_reset", 108'(o_Busy), 108'(1'b1));
                i_Reset = 1'b1;
                @(negedge i_Clock);
                check_value("reset_busy", 108'(o_Busy), 108'(1'b0));
                check_value("reset_dv", 108'(o_Rx_DV), 108'(1'b0));
                check_value("reset_err", 108'(o_Stuff_Err), 108'(1'b0));
                check_value("reset_byte", o_Rx_Byte, 108'(0));
                last_good   = '0;
                i_Reset     = 1'b0;
                i_Rx_Serial = 1'b1;
                return;
            end
            repeat (CLKS) @(negedge i_Clock);
        end
    endtask

    task automatic send_frame(input logic [0:107] stim, input logic [0:107] exp_frame);
        logic [0:127] s;
        int           n;
        exp_t         e;
        stuff_frame(stim, s, n);
        e.is_err  = 1'b0;
        e.frame   = exp_frame;
        e.crc_err = (crc15(exp_frame) != exp_frame[83:97]);
        sb.push_back(e);
        drive_bits(s, n, -1);
        idle_bits(4);
    endtask

    always @(negedge i_Clock) begin
        exp_t e;
        if (o_Rx_DV || o_Stuff_Err) begin
            if (sb.size() == 0) begin
                check_value("unexpected_event", {o_Rx_DV, o_Stuff_Err}, 108'(0));
            end else begin
                e = sb.pop_front();
                check_value("event_is_err", 108'(o_Stuff_Err), 108'(e.is_err));
                if (o_Rx_DV && !e.is_err) begin
                    check_value("frame", o_Rx_Byte, e.frame);
`ifdef CAN_RX_CRC_CHECK_EN
                    check_value("crc_err", 108'(o_Crc_Err), 108'(e.crc_err));
`endif
                    last_good = e.frame;
                end else if (o_Stuff_Err) begin
                    check_value("byte_held", o_Rx_Byte, last_good);
                end
            end
        end
    end

    initial begin
        logic [0:107] f1;
        logic [0:107] f1_exp;
        logic [0:107] f;
        logic [0:127] s;
        logic [0:127] bad;
        int           n;
        int           t;
        exp_t         e;

        n_checks    = 0;
        n_errors    = 0;
        last_good   = '0;
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        repeat (4) @(negedge i_Clock);
        check_value("rst_busy", 108'(o_Busy), 108'(1'b0));
        check_value("rst_dv", 108'(o_Rx_DV), 108'(1'b0));
        check_value("rst_err", 108'(o_Stuff_Err), 108'(1'b0));
        check_value("rst_byte", o_Rx_Byte, 108'(0));
        i_Reset = 1'b0;
        idle_bits(3);

        // Reference frame: three stuff bits on the wire
        f1     = make_frame(11'h014, 4'h1, 64'hAAAAAAAAAAAAAAAA, 15'h2180);
        f1_exp = {1'b0, 11'b00000010100, 3'b000, 4'b0001, {32{2'b10}},
                  15'b010000110000000, 10'b1011111111};
        stuff_frame(f1, s, n);
        check_value("frame1_stuffed_len", 108'(n), 108'(111));
        send_frame(f1, f1_exp);

        // Stuff error: SOF followed by seven dominant bits
        bad = '1;
        bad[0:7] = 8'h00;
        e.is_err  = 1'b1;
        e.frame   = '0;
        e.crc_err = 1'b0;
        sb.push_back(e);
        drive_bits(bad, 8, -1);
        idle_bits(4);

        // Short dominant glitch on an idle bus
        i_Rx_Serial = 1'b0;
        repeat (3) @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        repeat (12) @(negedge i_Clock);
        check_value("glitch_busy", 108'(o_Busy), 108'(1'b0));
        idle_bits(2);

        // Reset in the middle of a frame, then a clean frame
        drive_bits(s, n, 50);
        idle_bits(3);
        send_frame(f1, f1_exp);

        // CRC ending in five recessive bits forces a stuff bit right before the delimiter
        f = make_frame(11'h5A3, 4'h8, 64'h0123456789ABCDEF, 15'h2A5F);
        send_frame(f, f);

        // Random frames carrying a correct CRC
        for (int k = 0; k < 3; k++) begin
            f = make_frame(11'($urandom), 4'($urandom), {32'($urandom), 32'($urandom)}, 15'h0);
            f[83:97] = crc15(f);
            send_frame(f, f);
        end

`ifdef CAN_RX_CRC_CHECK_EN
        f = make_frame(11'h123, 4'h8, 64'hDEADBEEF01020304, 15'h0);
        f[83:97] = crc15(f);
        send_frame(f, f);
        f[90] = ~f[90];
        send_frame(f, f);
`endif

        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge i_Clock);
            t++;
        end
        check_value("scoreboard_drained", 108'(sb.size()), 108'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
